// File: rtl/train_ctrl_pkg.sv
// Types and constants shared by the train-controller blocks.
package train_ctrl_pkg;

  localparam int WIDTH_DEF   = 19;
  localparam int STATE_W_DEF = 4;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_COUNT = 2'd1,
    PH_DONE  = 2'd2
  } phase_e;

  // Controller state codes as driven on present_state.
  localparam logic [STATE_W_DEF-1:0] ST_RESET    = 4'd0;
  localparam logic [STATE_W_DEF-1:0] ST_STOPPED  = 4'd1;
  localparam logic [STATE_W_DEF-1:0] ST_DEPART   = 4'd2;
  localparam logic [STATE_W_DEF-1:0] ST_CRUISE   = 4'd3;
  localparam logic [STATE_W_DEF-1:0] ST_APPROACH = 4'd4;
  localparam logic [STATE_W_DEF-1:0] ST_BRAKE    = 4'd5;
  localparam logic [STATE_W_DEF-1:0] ST_DWELL    = 4'd6;

endpackage

// File: rtl/phase_timer.sv
// Phase countdown timer: reloads on controller state change or start, counts ticks,
// pulses expired at end of phase. Define PHASE_TIMER_AUTORELOAD_EN for periodic reload.
module phase_timer
  import train_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [STATE_W-1:0] present_state,
  input  logic               start,
  input  logic               tick,
  input  logic               hold,
  output logic [WIDTH-1:0]   remaining,
  output logic               running,
  output logic               expired
);

  phase_e             state_q;
  logic [WIDTH-1:0]   remaining_q;
  logic [STATE_W-1:0] prev_state_q;
  logic               expired_q;
  logic               running_q;
  logic               load_ev;
  logic               cnt_ev;

  assign load_ev = (present_state != prev_state_q) || start;
  assign cnt_ev  = (state_q == PH_COUNT) && tick && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PH_IDLE;
      remaining_q  <= '0;
      prev_state_q <= '0;
      expired_q    <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      prev_state_q <= present_state;
      expired_q    <= 1'b0;
      if (load_ev) begin
        // A zero-length phase ends immediately but still tells the controller.
        if (load_val != '0) begin
          remaining_q <= load_val;
          state_q     <= PH_COUNT;
          running_q   <= 1'b1;
        end else begin
          remaining_q <= '0;
          state_q     <= PH_DONE;
          running_q   <= 1'b0;
          expired_q   <= 1'b1;
        end
      end else if (cnt_ev) begin
        if (remaining_q <= WIDTH'(1)) begin
          expired_q <= 1'b1;
`ifdef PHASE_TIMER_AUTORELOAD_EN
          if (load_val != '0) begin
            remaining_q <= load_val;
          end else begin
            remaining_q <= '0;
            state_q     <= PH_DONE;
            running_q   <= 1'b0;
          end
`else
          remaining_q <= '0;
          state_q     <= PH_DONE;
          running_q   <= 1'b0;
`endif
        end else begin
          remaining_q <= remaining_q - WIDTH'(1);
        end
      end
    end
  end

  assign remaining = remaining_q;
  assign running   = running_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed self-checking bench for phase_timer.
module tb_phase_timer;
  localparam int W  = 19;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  load_val;
  logic [SW-1:0] present_state;
  logic          start, tick, hold;
  logic [W-1:0]  remaining;
  logic          running, expired;

  int checks = 0;
  int errors = 0;

  phase_timer #(.WIDTH(W), .STATE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .load_val(load_val), .present_state(present_state),
    .start(start), .tick(tick), .hold(hold),
    .remaining(remaining), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_val = '0; present_state = '0; start = 0; tick = 0; hold = 0;
    cyc(); cyc();
    checks++; if (remaining !== 19'd0) begin errors++; $display("FAIL reset_rem got %0d want 0", remaining); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", running); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_exp got %b want 0", expired); end
    rst_n = 1'b1;
    cyc();
    checks++; if (expired !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL rel_idle got exp=%b run=%b want 0 0", expired, running); end
  endtask

  task automatic test_zero_load();
    start = 1; load_val = '0;
    cyc(); start = 0;
    checks++; if (remaining !== 19'd0) begin errors++; $display("FAIL zl_rem got %0d want 0", remaining); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL zl_exp got %b want 1", expired); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL zl_run got %b want 0", running); end
    cyc();
    checks++; if (expired !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL zl_after got exp=%b run=%b want 0 0", expired, running); end
  endtask

  task automatic test_count();
    logic [W-1:0] exp_rem [6];
    exp_rem = '{19'd5, 19'd4, 19'd3, 19'd2, 19'd1, 19'd0};
    present_state = 4'd3; load_val = 19'd5; tick = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (remaining !== exp_rem[i]) begin errors++; $display("FAIL cnt_rem[%0d] got %0d want %0d", i, remaining, exp_rem[i]); end
      checks++; if (expired !== (i == 5)) begin errors++; $display("FAIL cnt_exp[%0d] got %b want %b", i, expired, i == 5); end
      checks++; if (running !== (i != 5)) begin errors++; $display("FAIL cnt_run[%0d] got %b want %b", i, running, i != 5); end
    end
    cyc();
    checks++; if (expired !== 1'b0 || remaining !== 19'd0) begin errors++; $display("FAIL cnt_post got exp=%b rem=%0d want 0 0", expired, remaining); end
    tick = 0;
  endtask

  task automatic test_hold();
    logic [W-1:0] er;
    present_state = 4'd5; load_val = 19'd4; tick = 0; hold = 0;
    cyc();
    checks++; if (remaining !== 19'd4 || running !== 1'b1) begin errors++; $display("FAIL hold_load got rem=%0d run=%b want 4 1", remaining, running); end
    for (int c = 1; c <= 20; c++) begin
      tick = (c % 3 == 0);
      hold = (c >= 4 && c <= 9);
      cyc();
      if (c < 3) er = 19'd4; else if (c < 12) er = 19'd3; else if (c < 15) er = 19'd2;
      else if (c < 18) er = 19'd1; else er = 19'd0;
      checks++; if (remaining !== er) begin errors++; $display("FAIL hold_rem[%0d] got %0d want %0d", c, remaining, er); end
      checks++; if (expired !== (c == 18)) begin errors++; $display("FAIL hold_exp[%0d] got %b want %b", c, expired, c == 18); end
    end
    tick = 0; hold = 0;
  endtask

  task automatic test_preempt();
    present_state = 4'd6; load_val = 19'd2; tick = 0;
    cyc();
    tick = 1; cyc();
    checks++; if (remaining !== 19'd1) begin errors++; $display("FAIL pre_setup got %0d want 1", remaining); end
    present_state = 4'd4; load_val = 19'd10; tick = 1;
    cyc(); tick = 0;
    checks++; if (remaining !== 19'd10) begin errors++; $display("FAIL pre_rem got %0d want 10", remaining); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL pre_exp got %b want 0", expired); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pre_run got %b want 1", running); end
    cyc();
    checks++; if (expired !== 1'b0 || remaining !== 19'd10) begin errors++; $display("FAIL pre_next got exp=%b rem=%0d want 0 10", expired, remaining); end
  endtask

  task automatic test_reset_mid();
    present_state = 4'd2; load_val = 19'd7; tick = 0;
    cyc();
    checks++; if (remaining !== 19'd7) begin errors++; $display("FAIL rm_setup got %0d want 7", remaining); end
    #2 rst_n = 1'b0; #1;
    checks++; if (remaining !== 19'd0 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL rm_async got rem=%0d run=%b exp=%b want 0 0 0", remaining, running, expired); end
    present_state = 4'd0; tick = 1;
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (expired !== 1'b0 || remaining !== 19'd0 || running !== 1'b0) begin errors++; $display("FAIL rm_post[%0d] got exp=%b rem=%0d run=%b want 0 0 0", i, expired, remaining, running); end
    end
    tick = 0;
  endtask

  task automatic test_autoreload();
    logic [W-1:0] er [9];
    logic         ee [9];
`ifdef PHASE_TIMER_AUTORELOAD_EN
    er = '{19'd2, 19'd1, 19'd3, 19'd2, 19'd1, 19'd3, 19'd2, 19'd1, 19'd3};
    ee = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    er = '{19'd2, 19'd1, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0};
    ee = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    present_state = 4'd1; load_val = 19'd3; tick = 1;
    cyc();
    checks++; if (remaining !== 19'd3) begin errors++; $display("FAIL ar_load got %0d want 3", remaining); end
    for (int i = 0; i < 9; i++) begin
      cyc();
      checks++; if (remaining !== er[i]) begin errors++; $display("FAIL ar_rem[%0d] got %0d want %0d", i, remaining, er[i]); end
      checks++; if (expired !== ee[i]) begin errors++; $display("FAIL ar_exp[%0d] got %b want %b", i, expired, ee[i]); end
    end
    tick = 0;
  endtask

  initial begin
    test_reset();
    test_zero_load();
    test_count();
    test_hold();
    test_preempt();
    test_reset_mid();
    test_autoreload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
